// File: rtl/c3lib_avmm_pulse_mux.sv
// ---------------------------------------------------------------------------
// c3lib_avmm_pulse_mux
//
// Collects rising edges on NCH request lines into per-channel saturating
// pending counters and issues them one at a time, round-robin, as
// single-cycle pulses tagged with a channel index. Issuing is paced by the
// downstream pulse-crossing stage's ready output. Requests that arrive while
// the downstream stage is busy are queued instead of dropped. A request that
// arrives at a saturated counter sets that channel's sticky overflow flag.
//
// Parameters:
//   NCH     : number of request channels (1..16)
//   CNT_W   : pending counter width; saturates at 2^CNT_W-1
//   MIN_GAP : extra idle cycles inserted after each issued pulse (0..255)
//   CW      : channel index width, max(1, clog2(NCH))
//
// Ports:
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset
//   i_pulse : per-channel request; each rising edge is one request
//   i_ready : downstream ready (next-pulse) indication, sampled in IDLE only
//   i_flush : synchronous clear of all counters and overflow flags
//   o_pulse : single-cycle issued pulse, decoded from the state register
//   o_chan  : channel of the current/last issued pulse
//   o_pend  : per-channel "counter non-zero"
//   o_ovf   : sticky per-channel overflow
//   o_busy  : FSM not IDLE, or any channel pending
// ---------------------------------------------------------------------------
module c3lib_avmm_pulse_mux #(
   parameter  int NCH     = 4,
   parameter  int CNT_W   = 4,
   parameter  int MIN_GAP = 0,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [NCH-1:0] i_pulse,
   input  logic           i_ready,
   input  logic           i_flush,
   output logic           o_pulse,
   output logic [CW-1:0]  o_chan,
   output logic [NCH-1:0] o_pend,
   output logic [NCH-1:0] o_ovf,
   output logic           o_busy
);

   localparam logic [1:0]       ST_IDLE  = 2'd0;
   localparam logic [1:0]       ST_ISSUE = 2'd1;
   localparam logic [1:0]       ST_HOLD  = 2'd2;
   localparam logic [1:0]       ST_GAP   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CW-1:0]    LAST_RST = CW'(NCH - 1);
   localparam logic [CW:0]      NCH_W    = (CW + 1)'(NCH);
   // GAP counts down from MIN_GAP-1 to 0, giving exactly MIN_GAP GAP cycles.
   localparam logic [7:0]       GAP_LOAD = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

   logic [NCH-1:0]   prev_r;
   logic [CNT_W-1:0] cnt_r [NCH];
   logic [NCH-1:0]   ovf_r;
   logic [1:0]       state_r;
   logic [CW-1:0]    last_r;
   logic [CW-1:0]    chan_r;
   logic [7:0]       gap_r;

   logic [NCH-1:0]   inc_s;
   logic [NCH-1:0]   dec_s;
   logic [NCH-1:0]   pend_s;
   logic [CW-1:0]    win_s;
   logic             win_vld_s;
   logic             sel_s;
   logic [CW:0]      rr_idx_s;

   assign inc_s = i_pulse & ~prev_r;

   // Per-channel pending flags straight from the counter registers.
   always_comb begin
      pend_s = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         pend_s[i] = (cnt_r[i] != CNT_ZERO);
      end
   end

   // Round-robin winner: first pending channel searching from last+1, wrapping.
   always_comb begin
      win_s     = {CW{1'b0}};
      win_vld_s = 1'b0;
      rr_idx_s  = {(CW + 1){1'b0}};
      for (int k = 1; k <= NCH; k++) begin
         rr_idx_s = {1'b0, last_r} + (CW + 1)'(k);
         if (rr_idx_s >= NCH_W) begin
            rr_idx_s = rr_idx_s - NCH_W;
         end else begin
            rr_idx_s = rr_idx_s;
         end
         if (!win_vld_s && pend_s[rr_idx_s[CW-1:0]]) begin
            win_vld_s = 1'b1;
            win_s     = rr_idx_s[CW-1:0];
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   assign sel_s = (state_r == ST_IDLE) && i_ready && win_vld_s;

   // One-hot decrement for the channel selected this cycle.
   always_comb begin
      dec_s = {NCH{1'b0}};
      if (sel_s) begin
         dec_s[win_s] = 1'b1;
      end else begin
         dec_s = {NCH{1'b0}};
      end
   end

   // Edge history, pending counters and sticky overflow flags.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prev_r <= {NCH{1'b0}};
         ovf_r  <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         // History always follows the input, so an edge seen during flush is consumed.
         prev_r <= i_pulse;
         if (i_flush) begin
            ovf_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
               cnt_r[i] <= CNT_ZERO;
            end
         end else begin
            for (int i = 0; i < NCH; i++) begin
               if (inc_s[i] && !dec_s[i]) begin
                  if (cnt_r[i] == CNT_MAX) begin
                     ovf_r[i] <= 1'b1;
                  end else begin
                     cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                  end
               end else if (dec_s[i] && !inc_s[i]) begin
                  cnt_r[i] <= cnt_r[i] - CNT_W'(1);
               end else begin
                  // Simultaneous inc and dec cancel, even when saturated.
                  cnt_r[i] <= cnt_r[i];
               end
            end
         end
      end
   end

   // Issue FSM with round-robin pointer, channel tag and gap counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         last_r  <= LAST_RST;
         chan_r  <= {CW{1'b0}};
         gap_r   <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sel_s) begin
                  state_r <= ST_ISSUE;
                  chan_r  <= win_s;
                  last_r  <= win_s;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               state_r <= ST_HOLD;
            end
            // Ready is ignored here to ride out the downstream registered ready drop.
            ST_HOLD: begin
               if (MIN_GAP > 0) begin
                  state_r <= ST_GAP;
                  gap_r   <= GAP_LOAD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_r == 8'd0) begin
                  state_r <= ST_IDLE;
               end else begin
                  gap_r <= gap_r - 8'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pulse = (state_r == ST_ISSUE);
   assign o_chan  = chan_r;
   assign o_pend  = pend_s;
   assign o_ovf   = ovf_r;
   assign o_busy  = (state_r != ST_IDLE) || (|pend_s);

endmodule

// File: tb/tb_c3lib_avmm_pulse_mux.sv
// ---------------------------------------------------------------------------
// tb_c3lib_avmm_pulse_mux
//
// Directed bench. dut_a (MIN_GAP=0) and dut_b (MIN_GAP=1) share stimulus;
// dut_c (CNT_W=2) has its own stimulus for the saturation cases.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_c3lib_avmm_pulse_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst, ready, flush;
   logic [3:0] pulse;
   logic       a_pulse, a_busy, b_pulse, b_busy;
   logic [1:0] a_chan, b_chan;
   logic [3:0] a_pend, a_ovf, b_pend, b_ovf;

   logic       c_rst, c_ready, c_flush;
   logic [3:0] c_pulse_in;
   logic       c_pulse, c_busy;
   logic [1:0] c_chan;
   logic [3:0] c_pend, c_ovf;

   c3lib_avmm_pulse_mux #(.NCH(4), .CNT_W(4), .MIN_GAP(0)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_ready(ready), .i_flush(flush),
      .o_pulse(a_pulse), .o_chan(a_chan), .o_pend(a_pend), .o_ovf(a_ovf), .o_busy(a_busy));

   c3lib_avmm_pulse_mux #(.NCH(4), .CNT_W(4), .MIN_GAP(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_ready(ready), .i_flush(flush),
      .o_pulse(b_pulse), .o_chan(b_chan), .o_pend(b_pend), .o_ovf(b_ovf), .o_busy(b_busy));

   c3lib_avmm_pulse_mux #(.NCH(4), .CNT_W(2), .MIN_GAP(0)) dut_c (
      .i_clk(clk), .i_rst(c_rst), .i_pulse(c_pulse_in), .i_ready(c_ready), .i_flush(c_flush),
      .o_pulse(c_pulse), .o_chan(c_chan), .o_pend(c_pend), .o_ovf(c_ovf), .o_busy(c_busy));

   int checks = 0;
   int failures = 0;

   int qa_chan[$];
   int qa_cyc[$];
   int qb_chan[$];
   int qb_cyc[$];
   int c_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; c_rst = 1'b1;
      pulse = 4'b0; c_pulse_in = 4'b0;
      ready = 1'b0; c_ready = 1'b0;
      flush = 1'b0; c_flush = 1'b0;
      tick();
      tick();
      rst = 1'b0; c_rst = 1'b0;
   endtask

   task automatic edges_a(input logic [3:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         pulse = p;    tick();
         pulse = 4'b0; tick();
      end
   endtask

   task automatic edges_c(input logic [3:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         c_pulse_in = p;    tick();
         c_pulse_in = 4'b0; tick();
      end
   endtask

   // Record every issued pulse (cycle and channel) over n cycles.
   task automatic collect(input int n);
      qa_chan.delete(); qa_cyc.delete(); qb_chan.delete(); qb_cyc.delete();
      c_cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (a_pulse) begin qa_chan.push_back(int'(a_chan)); qa_cyc.push_back(cyc); end
         if (b_pulse) begin qb_chan.push_back(int'(b_chan)); qb_cyc.push_back(cyc); end
         if (c_pulse) c_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int exp_rr[6];
      int bad;
      int found;
      exp_rr = '{0, 1, 3, 0, 1, 3};

      // Reset state
      do_reset();
      tick();
      check("rst_pulse", a_pulse, 0);
      check("rst_chan",  a_chan,  0);
      check("rst_pend",  a_pend,  0);
      check("rst_ovf",   a_ovf,   0);
      check("rst_busy",  a_busy,  0);

      // Single request on ch2: pend at t+1, pulse at t+2, idle at t+4
      ready = 1'b1;
      pulse = 4'b0100;
      tick();
      check("s1_pend",      a_pend,  4'b0100);
      check("s1_nopulse",   a_pulse, 0);
      pulse = 4'b0;
      tick();
      check("s1_pulse",     a_pulse, 1);
      check("s1_chan",      a_chan,  2);
      check("s1_pend_clr",  a_pend,  0);
      tick();
      check("s1_hold_busy", a_busy,  1);
      check("s1_hold_np",   a_pulse, 0);
      tick();
      check("s1_idle_busy", a_busy,  0);

      // Round-robin: 2 pending on ch0, ch1, ch3
      do_reset();
      edges_a(4'b1011, 2);
      check("rr_pend_a", a_pend, 4'b1011);
      check("rr_pend_b", b_pend, 4'b1011);
      ready = 1'b1;
      collect(30);
      check("rr_a_n", qa_chan.size(), 6);
      check("rr_b_n", qb_chan.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rr_a_ch%0d", i), (i < qa_chan.size()) ? qa_chan[i] : -1, exp_rr[i]);
         check($sformatf("rr_b_ch%0d", i), (i < qb_chan.size()) ? qb_chan[i] : -1, exp_rr[i]);
      end
      for (int i = 1; i < 6; i++) begin
         check($sformatf("rr_a_gap%0d", i), (i < qa_cyc.size()) ? qa_cyc[i] - qa_cyc[i-1] : -1, 3);
         check($sformatf("rr_b_gap%0d", i), (i < qb_cyc.size()) ? qb_cyc[i] - qb_cyc[i-1] : -1, 4);
      end

      // Back-pressure: 5 edges on ch1 while not ready, then drain
      do_reset();
      edges_a(4'b0010, 5);
      collect(10);
      check("bp_nopulse", qa_chan.size(), 0);
      check("bp_pend",    a_pend, 4'b0010);
      ready = 1'b1;
      collect(25);
      check("bp_n", qa_chan.size(), 5);
      bad = 0;
      foreach (qa_chan[i]) if (qa_chan[i] != 1) bad++;
      check("bp_chan", bad, 0);
      check("bp_ovf",  a_ovf, 0);
      check("bp_busy", a_busy, 0);

      // Flush coinciding with an IDLE selection
      do_reset();
      edges_a(4'b1000, 16);
      check("fl_ovf_set", a_ovf, 4'b1000);
      edges_a(4'b0100, 3);
      check("fl_pend", a_pend, 4'b1100);
      ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_pulse", a_pulse, 1);
      check("fl_chan",  a_chan,  2);
      check("fl_pend0", a_pend,  0);
      check("fl_ovf0",  a_ovf,   0);
      collect(15);
      check("fl_nomore", qa_chan.size(), 0);

      // Reset during ISSUE, with ch0 held high throughout
      do_reset();
      ready = 1'b1;
      pulse = 4'b0001;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         tick();
         if (a_pulse) found = 1;
      end
      check("rr_issue_seen", found, 1);
      rst = 1'b1;
      #1;
      check("rst_async_pulse", a_pulse, 0);
      check("rst_async_pend",  a_pend,  0);
      tick();
      rst = 1'b0;
      collect(20);
      check("rst_held_n",  qa_chan.size(), 1);
      check("rst_held_ch", (qa_chan.size() > 0) ? qa_chan[0] : -1, 0);
      pulse = 4'b0;

      // Saturation with CNT_W=2
      edges_c(4'b0001, 3);
      check("sat_pend3",   c_pend, 4'b0001);
      check("sat_noovf3",  c_ovf,  0);
      c_ready = 1'b1;
      c_pulse_in = 4'b0001;
      tick();
      c_ready = 1'b0;
      c_pulse_in = 4'b0;
      check("sat_incdec_pulse", c_pulse, 1);
      check("sat_incdec_ovf",   c_ovf,   0);
      tick();
      tick();
      c_ready = 1'b1;
      collect(15);
      check("sat_incdec_drain", c_cnt, 3);
      c_ready = 1'b0;
      edges_c(4'b0001, 5);
      check("sat_ovf", c_ovf, 4'b0001);
      c_ready = 1'b1;
      collect(15);
      check("sat_drain", c_cnt, 3);
      check("sat_sticky", c_ovf, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/c3lib_avmm_pulse_mux.md
# c3lib_avmm_pulse_mux

Single-clock, parametrised N-channel pulse collector and issuer for the AVMM pulse-crossing path. It captures rising edges on NCH independent request lines into per-channel saturating pending counters. Pending requests are issued one at a time, round-robin, as single-cycle pulses tagged with a channel index to a downstream pulse-crossing stage, paced by that stage's ready (next-pulse) output. Unlike a single pulse-crossing stage, which drops a pulse arriving while busy, this block queues pending requests per channel and flags overflow.

## Interface
- NCH, 4, number of request channels, 1..16
- CNT_W, 4, pending counter width per channel; saturates at 2^CNT_W-1
- MIN_GAP, 0, extra idle cycles inserted after each issued pulse, 0..255
- CW (localparam), max(1, $clog2(NCH)), channel index width
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_pulse  in  NCH  per-channel request; each rising edge is one request
- i_ready  in  1  downstream ready (next-pulse) indication
- i_flush  in  1  synchronous clear of all counters and overflow flags
- o_pulse  out  1  single-cycle issued pulse
- o_chan  out  CW  channel of the current/last issued pulse
- o_pend  out  NCH  per-channel counter non-zero
- o_ovf  out  NCH  sticky per-channel overflow
- o_busy  out  1  FSM not IDLE, or any channel pending

## Operation
- Edge detect: prev[i] register, reset 0. inc[i] = i_pulse[i] & ~prev[i]. A level held high counts once. A line high at reset release counts once.
- Counter update, per channel, at each clock:
  - inc & ~dec: cnt+1; at saturation cnt holds and ovf[i] is set.
  - dec & ~inc: cnt-1.
  - inc & dec: unchanged, no overflow, even when saturated.
- i_flush: cnt and ovf are cleared to 0. Edges in the flush cycle are discarded. The FSM is unaffected; an ISSUE already committed completes.
- FSM states:
  - IDLE: if i_ready & |o_pend, select the winner, set dec[winner], register o_chan and the rr pointer, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: o_pulse=1; next state HOLD.
  - HOLD: one cycle; i_ready is ignored to absorb the downstream registered ready drop. Next state GAP if MIN_GAP>0, else IDLE.
  - GAP: counts MIN_GAP cycles, then IDLE.
- Arbitration: round-robin. Search starts at last+1 and wraps modulo NCH. last resets to NCH-1, so channel 0 has first priority. Only channels with cnt!=0 are eligible.
- If flush and IDLE selection occur in the same cycle: the selection wins the decrement but the counter still clears. Flush has priority on cnt, and the pulse is still issued.
- o_pulse is decoded from the state register and is glitch-free.

## Timing
- Reset values: o_pulse 0, o_chan 0, o_pend 0, o_ovf 0, o_busy 0. State IDLE, rr last=NCH-1.
- o_pend is combinational from the counter registers. Edge at cycle t gives o_pend high at t+1.
- Minimum latency, i_ready high: i_pulse edge at t → selection at t+1 → o_pulse at t+2.
- Throughput with i_ready held high: one pulse per 3+MIN_GAP cycles.
- i_ready is sampled only in IDLE. Ready low holds the FSM in IDLE indefinitely, with no loss of counts.
- o_chan is stable from the ISSUE cycle until the next selection.
- Reset asserted mid-operation clears everything immediately. o_pulse deasserts asynchronously.

## Test plan
- Single request: NCH=4, i_ready=1, one-cycle pulse on ch2 at t=10 → o_pend[2] at 11; o_pulse at 12 with o_chan=2; o_pend[2]=0 at 12; o_busy low at 14.
- Round-robin: ch0, ch1 and ch3 each have 2 pending, i_ready=1 → issue order 0,1,3,0,1,3, spaced 3 cycles apart (MIN_GAP=0), then 4 cycles apart with MIN_GAP=1.
- Back-pressure: i_ready=0 while 5 edges arrive on ch1 → no o_pulse, cnt=5. Raise i_ready → 5 pulses issued, o_ovf=0.
- Saturation: CNT_W=2, i_ready=0, 5 edges on ch0 → cnt=3, o_ovf[0]=1. Edge on the same cycle as a decrement at cnt=3 → cnt stays 3, no new overflow.
- Flush: 3 pending on ch2, with i_flush coinciding with an IDLE selection → that one pulse is issued; cnt=0 and o_ovf cleared next cycle; no further pulses.
- Reset mid-ISSUE: assert i_rst while o_pulse=1 → o_pulse drops immediately. After release, a held-high i_pulse[0] produces exactly one pulse.
